// File: rtl/note_scheduler.sv
// note_scheduler
//
// Sequencing controller for the sine-wave sample datapath.
//  - Accepts notes (pitch index + duration in beats) over a valid/ready
//    handshake, looks up the phase step in an external synchronous ROM,
//    drives step_size to the sine reader and counts beats until the note
//    expires (note_done pulse).
//  - Turns codec sample requests into fixed-latency (4 cycle) output
//    strobes. Requests that are not audible (rest, pause, idle) return 0
//    and never advance the sine reader.
//
// Ports
//  clk, reset          clock; asynchronous active-high reset
//  play                level, 0 = pause (beats ignored, output silent)
//  note_valid/ready    note handshake; ready is high exactly in IDLE
//  note, duration      pitch index (0 = rest) and length in beats
//  beat                one-cycle beat pulse
//  rom_addr/rom_data   frequency ROM port, one cycle read latency
//  step_size           phase step to sine reader
//  generate_next       one-cycle advance pulse to sine reader
//  sample_request      codec sample request pulse
//  sample_ready/in     sine reader sample strobe and data
//  sample_out(_valid)  gated sample to codec with one-cycle strobe
//  note_done           one-cycle pulse at note end
//  sync_err            sticky; sine reader strobe did not line up
module note_scheduler #(
  parameter int NOTE_W = 6,
  parameter int DUR_W  = 6,
  parameter int STEP_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              note_valid,
  input  logic [NOTE_W-1:0] note,
  input  logic [DUR_W-1:0]  duration,
  output logic              note_ready,
  input  logic              beat,
  output logic [NOTE_W-1:0] rom_addr,
  input  logic [STEP_W-1:0] rom_data,
  output logic [STEP_W-1:0] step_size,
  output logic              generate_next,
  input  logic              sample_request,
  input  logic              sample_ready,
  input  logic [15:0]       sample_in,
  output logic [15:0]       sample_out,
  output logic              sample_out_valid,
  output logic              note_done,
  output logic              sync_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    LOAD   = 2'd2,
    PLAY   = 2'd3
  } state_t;

  state_t            state;
  logic [NOTE_W-1:0] note_reg;
  logic [DUR_W-1:0]  dur_reg;
  logic [DUR_W-1:0]  remaining;

  // Stage i holds the request seen i+1 cycles ago and whether it was audible.
  logic [2:0]        req_pipe;
  logic [2:0]        aud_pipe;
  logic              audible;
  logic              expect_sample;

  // Audible is judged from the pre-edge state in the cycle the request is seen.
  assign audible       = (state == PLAY) && play && (note_reg != '0);
  assign generate_next = req_pipe[0] & aud_pipe[0];
  assign expect_sample = req_pipe[2] & aud_pipe[2];

  // Note sequencing FSM. note_ready is kept as a register that tracks the
  // next state, so it equals (state == IDLE) in every cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      note_ready <= 1'b1;
      note_reg   <= '0;
      dur_reg    <= '0;
      remaining  <= '0;
      rom_addr   <= '0;
      step_size  <= '0;
      note_done  <= 1'b0;
    end else begin
      note_done <= 1'b0;
      case (state)
        IDLE: begin
          if (note_valid) begin
            note_reg <= note;
            dur_reg  <= duration;
            if (duration == '0) begin
              // Zero-length note: finish at once, leave the ROM untouched.
              note_done <= 1'b1;
            end else begin
              rom_addr   <= note;
              state      <= LOOKUP;
              note_ready <= 1'b0;
            end
          end
        end
        LOOKUP: begin
          // The ROM registers rom_addr on this edge.
          state <= LOAD;
        end
        LOAD: begin
          step_size <= (note_reg == '0) ? '0 : rom_data;
          remaining <= dur_reg;
          state     <= PLAY;
        end
        PLAY: begin
          // Beats during pause are dropped, which freezes the duration.
          if (beat && play) begin
            if (remaining == DUR_W'(1)) begin
              state      <= IDLE;
              note_ready <= 1'b1;
              step_size  <= '0;
              note_done  <= 1'b1;
            end else begin
              remaining <= remaining - DUR_W'(1);
            end
          end
        end
        default: begin
          state      <= IDLE;
          note_ready <= 1'b1;
        end
      endcase
    end
  end

  // Fixed-latency sample path. Every request produces exactly one strobe
  // four cycles later; the audible bit travels with it so in-flight
  // requests finish correctly even if play, the note or the state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_pipe         <= '0;
      aud_pipe         <= '0;
      sample_out       <= '0;
      sample_out_valid <= 1'b0;
      sync_err         <= 1'b0;
    end else begin
      req_pipe         <= {req_pipe[1:0], sample_request};
      aud_pipe         <= {aud_pipe[1:0], sample_request & audible};
      sample_out_valid <= req_pipe[2];
      if (req_pipe[2]) begin
        sample_out <= aud_pipe[2] ? sample_in : 16'd0;
      end
      // The sine reader must strobe exactly when an audible request reaches
      // the capture stage; any other strobe pattern means the two sides
      // have drifted apart.
      if (sample_ready != expect_sample) begin
        sync_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Testbench for note_scheduler: directed stimulus, a cycle-level behavioural
// model built from timestamps and queues, one per-cycle compare process and
// a few hand-computed literal checks.
module tb_note_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        play = 1'b1;
  logic        note_valid = 1'b0;
  logic [5:0]  note = '0;
  logic [5:0]  duration = '0;
  logic        note_ready;
  logic        beat = 1'b0;
  logic [5:0]  rom_addr;
  logic [19:0] rom_data = '0;
  logic [19:0] step_size;
  logic        generate_next;
  logic        sample_request = 1'b0;
  logic        sample_ready;
  logic [15:0] sample_in;
  logic [15:0] sample_out;
  logic        sample_out_valid;
  logic        note_done;
  logic        sync_err;
  logic        inject = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  note_scheduler #(.NOTE_W(6), .DUR_W(6), .STEP_W(20)) dut (
    .clk(clk), .reset(rst), .play(play),
    .note_valid(note_valid), .note(note), .duration(duration),
    .note_ready(note_ready), .beat(beat),
    .rom_addr(rom_addr), .rom_data(rom_data), .step_size(step_size),
    .generate_next(generate_next), .sample_request(sample_request),
    .sample_ready(sample_ready), .sample_in(sample_in),
    .sample_out(sample_out), .sample_out_valid(sample_out_valid),
    .note_done(note_done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // Frequency ROM contents: note 10 is pinned, others follow a simple pattern.
  function automatic logic [19:0] rom_fn(input logic [5:0] a);
    if (a == 6'd10) return 20'h01000;
    return {a, 14'h0155};
  endfunction

  always @(posedge clk) rom_data <= rom_fn(rom_addr);

  // Sine reader: answers each generate_next two cycles later with a
  // numbered sample.
  logic        sr1, sr2;
  logic [15:0] sine_cnt;
  logic [15:0] sine_val;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sr1 <= 1'b0; sr2 <= 1'b0; sine_cnt <= '0; sine_val <= '0;
    end else begin
      sr1 <= generate_next;
      sr2 <= sr1;
      if (sr1) begin
        sine_val <= 16'hA000 + sine_cnt;
        sine_cnt <= sine_cnt + 16'd1;
      end
    end
  end
  assign sample_ready = sr2 | inject;
  assign sample_in    = sine_val;

  // ---------------- behavioural model ----------------
  typedef struct {
    int          due;
    logic [15:0] val;
  } exp_t;

  exp_t        vq[$];
  int          gq[$];
  logic        m_active = 1'b0;
  int          m_play_start = 0;
  int          m_rem = 0;
  logic [5:0]  m_note = '0;
  logic [5:0]  m_rom_addr = '0;
  logic [19:0] m_step_val = '0;
  int          m_done_at = -1;
  logic        m_sync = 1'b0;
  logic [15:0] m_aud_count = '0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        vq.delete(); gq.delete();
        m_active = 1'b0; m_rem = 0; m_note = '0; m_rom_addr = '0;
        m_step_val = '0; m_done_at = -1; m_sync = 1'b0; m_aud_count = '0;
      end else begin
        int  c;
        logic idle_pre, aud;
        c = cyc;
        idle_pre = !m_active;
        aud = m_active && (c >= m_play_start) && play && (m_note != 6'd0);
        if (sample_request) begin
          if (aud) begin
            gq.push_back(c + 1);
            vq.push_back('{c + 4, 16'hA000 + m_aud_count});
            m_aud_count = m_aud_count + 16'd1;
          end else begin
            vq.push_back('{c + 4, 16'h0000});
          end
        end
        if (inject) m_sync = 1'b1;
        if (m_active && (c >= m_play_start) && beat && play) begin
          m_rem = m_rem - 1;
          if (m_rem == 0) begin
            m_active  = 1'b0;
            m_done_at = c + 1;
          end
        end
        if (idle_pre && note_valid) begin
          if (duration == 6'd0) begin
            m_done_at = c + 1;
          end else begin
            m_active     = 1'b1;
            m_note       = note;
            m_rom_addr   = note;
            m_rem        = int'(duration);
            m_play_start = c + 3;
            m_step_val   = (note == 6'd0) ? 20'd0 : rom_fn(note);
          end
        end
        cyc = cyc + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model.
  initial begin
    forever begin
      @(negedge clk);
      begin
        logic        eg, ev;
        logic [15:0] evl;
        logic [19:0] es;
        es = (m_active && (cyc >= m_play_start)) ? m_step_val : 20'd0;
        eg = 1'b0; ev = 1'b0; evl = '0;
        if (gq.size() > 0 && gq[0] == cyc) begin
          eg = 1'b1;
          void'(gq.pop_front());
        end
        if (vq.size() > 0 && vq[0].due == cyc) begin
          ev  = 1'b1;
          evl = vq[0].val;
          void'(vq.pop_front());
        end
        chk("note_ready", 32'(note_ready), 32'(!m_active));
        chk("step_size", 32'(step_size), 32'(es));
        chk("rom_addr", 32'(rom_addr), 32'(m_rom_addr));
        chk("note_done", 32'(note_done), 32'(cyc == m_done_at));
        chk("generate_next", 32'(generate_next), 32'(eg));
        chk("sample_out_valid", 32'(sample_out_valid), 32'(ev));
        chk("sync_err", 32'(sync_err), 32'(m_sync));
        if (ev) begin
          chk("sample_out", 32'(sample_out), 32'(evl));
          $display("sample strobe cycle %0d value %h", cyc, sample_out);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic accept(input logic [5:0] n, input logic [5:0] d);
    $display("note accept note=%0d duration=%0d cycle %0d", n, d, cyc);
    note_valid = 1'b1; note = n; duration = d;
    tick();
    note_valid = 1'b0;
  endtask

  // Issue k back-to-back requests, then let the pipeline drain, counting
  // generate_next pulses and output strobes; cons reports whether the
  // strobes formed one unbroken run.
  task automatic req_burst(input int k, output int gens, output int vals, output int cons);
    int first, last, idx;
    gens = 0; vals = 0; first = -1; last = -1; idx = 0;
    $display("request burst of %0d cycle %0d", k, cyc);
    for (int i = 0; i < k + 6; i++) begin
      sample_request = (i < k);
      tick();
      idx++;
      if (generate_next) gens++;
      if (sample_out_valid) begin
        vals++;
        if (first < 0) first = idx;
        last = idx;
      end
    end
    sample_request = 1'b0;
    cons = (vals > 0 && (last - first + 1) == vals) ? 1 : 0;
  endtask

  // Pulse beats until note_done shows up; n = beats used (99 if it never ends).
  task automatic beat_until_done(output int n);
    n = 99;
    for (int i = 1; i <= 12; i++) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
      if (note_done) begin
        n = i;
        break;
      end
      tick();
    end
    $display("note ended after %0d beats cycle %0d", n, cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  initial begin
    int g, v, cs, n;
    repeat (3) tick();
    chk("reset_note_ready", 32'(note_ready), 32'd1);
    chk("reset_step_size", 32'(step_size), 32'd0);
    chk("reset_note_done", 32'(note_done), 32'd0);
    chk("reset_valid", 32'(sample_out_valid), 32'd0);
    rst = 1'b0;
    tick();

    // Lookup and duration; a beat during LOOKUP must be ignored.
    accept(6'd10, 6'd3);
    beat = 1'b1;
    chk("lookup_rom_addr", 32'(rom_addr), 32'd10);
    chk("lookup_not_ready", 32'(note_ready), 32'd0);
    tick();
    beat = 1'b0;
    tick();
    chk("load_step_size", 32'(step_size), 32'h01000);
    for (int i = 0; i < 3; i++) begin
      beat = 1'b1;
      tick();
      beat = 1'b0;
      chk("dur_note_done", 32'(note_done), 32'(i == 2));
      chk("dur_note_ready", 32'(note_ready), 32'(i == 2));
      if (i < 2) tick();
    end
    chk("end_step_size", 32'(step_size), 32'd0);

    // Zero duration, accepted in the same cycle note_done is high.
    accept(6'd33, 6'd0);
    chk("zero_dur_done", 32'(note_done), 32'd1);
    chk("zero_dur_ready", 32'(note_ready), 32'd1);
    chk("zero_dur_rom_addr", 32'(rom_addr), 32'd10);
    tick();
    chk("zero_dur_single", 32'(note_done), 32'd0);

    // Rest note: silent samples, no sine advance.
    accept(6'd0, 6'd2);
    tick(); tick();
    req_burst(2, g, v, cs);
    chk("rest_gens", 32'(g), 32'd0);
    chk("rest_vals", 32'(v), 32'd2);
    beat_until_done(n);
    chk("rest_beats", 32'(n), 32'd2);

    // Pause: 2 beats played, 5 beats paused, then 6 remaining.
    accept(6'd5, 6'd8);
    tick(); tick();
    for (int i = 0; i < 2; i++) begin
      beat = 1'b1; tick(); beat = 1'b0; tick();
    end
    play = 1'b0;
    for (int i = 0; i < 5; i++) begin
      beat = 1'b1; tick(); beat = 1'b0; tick();
    end
    req_burst(3, g, v, cs);
    chk("pause_gens", 32'(g), 32'd0);
    chk("pause_vals", 32'(v), 32'd3);
    play = 1'b1;
    beat_until_done(n);
    chk("pause_remaining_beats", 32'(n), 32'd6);

    // Back-to-back audible requests.
    accept(6'd7, 6'd4);
    tick(); tick();
    req_burst(8, g, v, cs);
    chk("b2b_gens", 32'(g), 32'd8);
    chk("b2b_vals", 32'(v), 32'd8);
    chk("b2b_consecutive", 32'(cs), 32'd1);
    chk("b2b_sync_err", 32'(sync_err), 32'd0);
    // An in-flight audible request survives a pause.
    sample_request = 1'b1;
    tick();
    sample_request = 1'b0;
    play = 1'b0;
    tick(); tick();
    play = 1'b1;
    repeat (4) tick();
    beat_until_done(n);
    chk("b2b_note_beats", 32'(n), 32'd4);

    // Reset mid-PLAY with two requests in flight.
    accept(6'd12, 6'd5);
    tick(); tick();
    sample_request = 1'b1;
    tick(); tick();
    sample_request = 1'b0;
    #2 rst = 1'b1;
    $display("async reset asserted cycle %0d", cyc);
    #1;
    chk("rst_note_ready", 32'(note_ready), 32'd1);
    chk("rst_step_size", 32'(step_size), 32'd0);
    chk("rst_generate_next", 32'(generate_next), 32'd0);
    chk("rst_valid", 32'(sample_out_valid), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_sample_out", 32'(sample_out), 32'd0);
    tick(); tick();
    rst = 1'b0;
    v = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (sample_out_valid) v++;
    end
    chk("rst_no_late_valid", 32'(v), 32'd0);

    // Spurious sample_ready: sticky sync_err until reset.
    $display("inject spurious sample_ready cycle %0d", cyc);
    inject = 1'b1;
    tick();
    inject = 1'b0;
    chk("sync_set", 32'(sync_err), 32'd1);
    repeat (5) tick();
    chk("sync_held", 32'(sync_err), 32'd1);
    rst = 1'b1;
    tick();
    chk("sync_cleared", 32'(sync_err), 32'd0);
    rst = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
